seg_scan_driver: RTL and testbench



---
 rtl/seg_scan_driver.sv | 103 ++++++++++
 tb/tb_seg_scan_driver.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scanner: one digit lit per slot, active-low buses, registered outputs.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN darkens leading zero digits.
module seg_scan_driver #(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 100000,
   parameter int DEAD_CYCLES = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic [4*NUM_DIGITS-1:0]       digit_data,
   input  logic [NUM_DIGITS-1:0]         dp_in,
   input  logic [NUM_DIGITS-1:0]         blank_mask,
   output logic [NUM_DIGITS-1:0]         an_n,
   output logic [6:0]                    seg_n,
   output logic                          dp_n,
   output logic [$clog2(NUM_DIGITS)-1:0] scan_idx
);

   localparam int IW = $clog2(NUM_DIGITS);
   localparam int CW = $clog2(REFRESH_DIV);

   logic [CW-1:0]                cnt;
   logic [NUM_DIGITS-1:0][3:0]   nib;
   logic [NUM_DIGITS-1:0]        dark;
   logic [NUM_DIGITS-1:0]        onehot;
   logic [NUM_DIGITS-1:0]        an_d;
   logic [6:0]                   seg_d;
   logic                         dp_d;
   logic                         lit;

   assign nib = digit_data;

   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

`ifdef SEG_LEADING_ZERO_BLANK_EN
   // zchain[i]: nibble i and all above are zero with no decimal point set on any of them
   logic [NUM_DIGITS:1] zchain;
   assign zchain[NUM_DIGITS] = 1'b1;
   for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_lz
      assign zchain[i] = zchain[i+1] & (nib[i] == 4'h0) & ~dp_in[i];
   end
   assign dark = blank_mask | {zchain[NUM_DIGITS-1:1], 1'b0};
`else
   assign dark = blank_mask;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt      <= '0;
         scan_idx <= '0;
      end else if (en) begin
         if (cnt == CW'(REFRESH_DIV - 1)) begin
            cnt      <= '0;
            scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + IW'(1);
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // Dead time at slot start keeps the previous anode fully off before the next turns on
   always_comb begin
      onehot           = '0;
      onehot[scan_idx] = 1'b1;
      lit   = en && (cnt >= CW'(DEAD_CYCLES)) && !dark[scan_idx];
      an_d  = lit ? ~onehot : '1;
      seg_d = lit ? hex7(nib[scan_idx]) : 7'h7F;
      dp_d  = lit ? ~dp_in[scan_idx] : 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         an_n  <= '1;
         seg_n <= 7'h7F;
         dp_n  <= 1'b1;
      end else begin
         an_n  <= an_d;
         seg_n <= seg_d;
         dp_n  <= dp_d;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with 4 digits, 4-cycle slots, 1 dead cycle.
module tb_seg_scan_driver;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b1;
   logic [15:0] digit_data = 16'h1234;
   logic [3:0]  dp_in = 4'h0;
   logic [3:0]  blank_mask = 4'h0;
   logic [3:0]  an_n;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [1:0]  scan_idx;

   int checks = 0;
   int errors = 0;

   logic [3:0] an_tab [4];
   logic [6:0] exp_seg [4];
   bit         exp_lit [4];
   logic       exp_dp [4];

   seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .digit_data(digit_data), .dp_in(dp_in),
      .blank_mask(blank_mask), .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n), .scan_idx(scan_idx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // k = clock edges since reset release; output reflects state before edge k
   task automatic chk_cyc(input int k);
      int  oc, oi;
      bit  l;
      oc = (k - 1) % 4;
      oi = ((k - 1) / 4) % 4;
      l  = (oc != 0) && exp_lit[oi];
      chk($sformatf("an k=%0d", k), 16'(an_n), l ? 16'(an_tab[oi]) : 16'hF);
      chk($sformatf("seg k=%0d", k), 16'(seg_n), l ? 16'(exp_seg[oi]) : 16'h7F);
      chk($sformatf("dp k=%0d", k), 16'(dp_n), l ? 16'(exp_dp[oi]) : 16'h1);
      chk($sformatf("idx k=%0d", k), 16'(scan_idx), 16'((k / 4) % 4));
      chk($sformatf("onecold k=%0d", k), 16'($countones(~an_n) <= 1), 16'h1);
   endtask

   task automatic set_exp_1234();
      exp_seg[0] = 7'b0011001;
      exp_seg[1] = 7'b0110000;
      exp_seg[2] = 7'b0100100;
      exp_seg[3] = 7'b1111001;
      for (int i = 0; i < 4; i++) begin
         exp_lit[i] = 1'b1;
         exp_dp[i]  = 1'b1;
      end
   endtask

   initial begin
      an_tab[0] = 4'b1110;
      an_tab[1] = 4'b1101;
      an_tab[2] = 4'b1011;
      an_tab[3] = 4'b0111;
      set_exp_1234();

      // reset
      repeat (3) tick();
      chk("rst an", 16'(an_n), 16'hF);
      chk("rst seg", 16'(seg_n), 16'h7F);
      chk("rst dp", 16'(dp_n), 16'h1);
      chk("rst idx", 16'(scan_idx), 16'h0);
      rst_n = 1'b1;

      // full scan with wrap
      for (int k = 1; k <= 20; k++) begin
         tick();
         chk_cyc(k);
      end

      // blank digit 2, decimal point on digit 1
      blank_mask = 4'b0100;
      dp_in      = 4'b0010;
      exp_lit[2] = 1'b0;
      exp_dp[1]  = 1'b0;
      for (int k = 21; k <= 36; k++) begin
         tick();
         chk_cyc(k);
      end
      blank_mask = 4'b0000;
      dp_in      = 4'b0000;
      set_exp_1234();
      for (int k = 37; k <= 38; k++) begin
         tick();
         chk_cyc(k);
      end

      // freeze at cnt=2, scan_idx=1
      en = 1'b0;
      tick();
      chk("frz an", 16'(an_n), 16'hF);
      chk("frz seg", 16'(seg_n), 16'h7F);
      chk("frz idx", 16'(scan_idx), 16'h1);
      repeat (9) tick();
      chk("frz10 an", 16'(an_n), 16'hF);
      chk("frz10 idx", 16'(scan_idx), 16'h1);
      en = 1'b1;
      tick();
      chk("res1 an", 16'(an_n), 16'b1101);
      chk("res1 seg", 16'(seg_n), 16'b0110000);
      chk("res1 idx", 16'(scan_idx), 16'h1);
      tick();
      chk("res2 an", 16'(an_n), 16'b1101);
      chk("res2 idx", 16'(scan_idx), 16'h2);
      tick();
      chk("res3 an", 16'(an_n), 16'hF);
      tick();
      chk("res4 an", 16'(an_n), 16'b1011);
      chk("res4 seg", 16'(seg_n), 16'b0100100);

      // mid-slot reset at scan_idx=3, cnt=2
      repeat (4) tick();
      chk("pre idx", 16'(scan_idx), 16'h3);
      chk("pre an", 16'(an_n), 16'b0111);
      rst_n = 1'b0;
      tick();
      chk("mrst idx", 16'(scan_idx), 16'h0);
      chk("mrst an", 16'(an_n), 16'hF);
      chk("mrst seg", 16'(seg_n), 16'h7F);
      chk("mrst dp", 16'(dp_n), 16'h1);
      rst_n = 1'b1;
      tick();
      chk("rel1 an", 16'(an_n), 16'hF);
      tick();
      chk("rel2 an", 16'(an_n), 16'b1110);
      chk("rel2 seg", 16'(seg_n), 16'b0011001);

`ifdef SEG_LEADING_ZERO_BLANK_EN
      rst_n      = 1'b0;
      digit_data = 16'h0050;
      tick();
      rst_n = 1'b1;
      exp_seg[0] = 7'b1000000;
      exp_seg[1] = 7'b0010010;
      exp_lit[2] = 1'b0;
      exp_lit[3] = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk_cyc(k);
      end
      rst_n      = 1'b0;
      digit_data = 16'h0000;
      tick();
      rst_n = 1'b1;
      exp_lit[1] = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk_cyc(k);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
